// File: rtl/mc6502_intr_seq.sv
// rtl/mc6502_intr_seq.sv - mc6502 RESET/NMI/IRQ/BRK sequencer: dummy read, push PCH/PCL/P, set I, fetch vector.
// Optional MC6502_INTR_SYNC_EN adds two-flop synchronisers on NMI_N and IRQ_N.
module mc6502_intr_seq #(
  parameter logic [7:0] P_VEC_NMI = 8'hfa,
  parameter logic [7:0] P_VEC_RES = 8'hfc,
  parameter logic [7:0] P_VEC_IRQ = 8'hfe
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       NMI_N,
  input  logic       IRQ_N,
  input  logic       I_FLAG,
  input  logic       INSTR_DONE,
  input  logic       BRK_REQ,
  output logic       BUSY,
  output logic [2:0] STEP,
  output logic [1:0] AB_SEL,
  output logic [7:0] VEC_LO,
  output logic [2:0] DB_OUT_SRC,
  output logic       WR,
  output logic       S_DEC,
  output logic       B_FLAG,
  output logic       DL_WE,
  output logic       SET_I,
  output logic       PC_LOAD
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_T1       = 3'd1,
    S_T2       = 3'd2,
    S_T3       = 3'd3,
    S_T4       = 3'd4,
    S_T5       = 3'd5,
    S_T6       = 3'd6,
    S_RST_WAIT = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    K_RESET = 2'd0,
    K_NMI   = 2'd1,
    K_IRQ   = 2'd2,
    K_BRK   = 2'd3
  } kind_t;

  state_t     state, state_nxt;
  kind_t      kind, kind_nxt;
  logic [7:0] vec, vec_nxt;
  logic       nmi_pend, nmi_clr;
  logic       nmi_q;
  logic       nmi_s, irq_s;
  logic       nmi_edge;

`ifdef MC6502_INTR_SYNC_EN
  logic [1:0] nmi_sync, irq_sync;

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      nmi_sync <= 2'b11;
      irq_sync <= 2'b11;
    end else begin
      nmi_sync <= {nmi_sync[0], NMI_N};
      irq_sync <= {irq_sync[0], IRQ_N};
    end
  end

  assign nmi_s = nmi_sync[1];
  assign irq_s = irq_sync[1];
`else
  assign nmi_s = NMI_N;
  assign irq_s = IRQ_N;
`endif

  assign nmi_edge = nmi_q & ~nmi_s;

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    vec_nxt   = vec;
    nmi_clr   = 1'b0;
    case (state)
      S_RST_WAIT: begin
        state_nxt = S_T1;
        kind_nxt  = K_RESET;
      end
      S_IDLE: begin
        // Interrupts only at an instruction boundary; they outrank a same-cycle BRK.
        if (INSTR_DONE && nmi_pend) begin
          state_nxt = S_T1;
          kind_nxt  = K_NMI;
        end else if (INSTR_DONE && !irq_s && !I_FLAG) begin
          state_nxt = S_T1;
          kind_nxt  = K_IRQ;
        end else if (BRK_REQ) begin
          state_nxt = S_T1;
          kind_nxt  = K_BRK;
        end
      end
      S_T1: state_nxt = S_T2;
      S_T2: state_nxt = S_T3;
      S_T3: state_nxt = S_T4;
      S_T4: begin
        state_nxt = S_T5;
        // Vector is chosen here so a late NMI can hijack an IRQ/BRK in flight.
        if (kind == K_RESET) begin
          vec_nxt = P_VEC_RES;
        end else if (kind == K_NMI || nmi_pend) begin
          vec_nxt = P_VEC_NMI;
          nmi_clr = 1'b1;
        end else begin
          vec_nxt = P_VEC_IRQ;
        end
      end
      S_T5:    state_nxt = S_T6;
      S_T6:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state      <= S_RST_WAIT;
      kind       <= K_RESET;
      vec        <= 8'h00;
      nmi_pend   <= 1'b0;
      nmi_q      <= 1'b1;
      BUSY       <= 1'b1;
      STEP       <= 3'd0;
      AB_SEL     <= 2'd0;
      VEC_LO     <= 8'h00;
      DB_OUT_SRC <= 3'd0;
      WR         <= 1'b0;
      S_DEC      <= 1'b0;
      B_FLAG     <= 1'b0;
      DL_WE      <= 1'b0;
      SET_I      <= 1'b0;
      PC_LOAD    <= 1'b0;
    end else begin
      state    <= state_nxt;
      kind     <= kind_nxt;
      vec      <= vec_nxt;
      nmi_q    <= nmi_s;
      nmi_pend <= nmi_edge | (nmi_pend & ~nmi_clr);

      // Outputs are decoded from the next state so they line up with the state register.
      BUSY       <= (state_nxt != S_IDLE);
      STEP       <= (state_nxt == S_RST_WAIT) ? 3'd0 : state_nxt;
      AB_SEL     <= 2'd0;
      VEC_LO     <= 8'h00;
      DB_OUT_SRC <= 3'd0;
      WR         <= 1'b0;
      S_DEC      <= 1'b0;
      B_FLAG     <= 1'b0;
      DL_WE      <= 1'b0;
      SET_I      <= 1'b0;
      PC_LOAD    <= 1'b0;
      case (state_nxt)
        S_T2, S_T3, S_T4: begin
          AB_SEL <= 2'd1;
          S_DEC  <= 1'b1;
          WR     <= (kind_nxt != K_RESET);
          if (state_nxt == S_T2) DB_OUT_SRC <= 3'd6;
          else if (state_nxt == S_T3) DB_OUT_SRC <= 3'd5;
          else begin
            DB_OUT_SRC <= 3'd4;
            B_FLAG     <= (kind_nxt == K_BRK);
          end
        end
        S_T5: begin
          AB_SEL <= 2'd2;
          VEC_LO <= vec_nxt;
          DL_WE  <= 1'b1;
          SET_I  <= 1'b1;
        end
        S_T6: begin
          AB_SEL  <= 2'd2;
          VEC_LO  <= {vec_nxt[7:1], 1'b1};
          PC_LOAD <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
